// File: rtl/seg_scan_if.sv
// Load channel of the 7-segment scan controller: a packed hex value plus
// decimal-point enables, moved with a valid/ready handshake.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load_valid;
  logic                      load_ready;
  logic [4*NUM_DIGITS-1:0]   load_data;
  logic [NUM_DIGITS-1:0]     load_dp;

  modport master (output load_valid, output load_data, output load_dp, input load_ready);
  modport slave  (input load_valid, input load_data, input load_dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner. New values are double-buffered
// and only take effect at a frame boundary so a frame never mixes two values.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_if.slave             load_if,
  input  logic                  blank_lz_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]         PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [PW-1:0]           presc_q;
  logic [IW-1:0]           idx_q;
  logic                    pending_q;
  logic [4*NUM_DIGITS-1:0] pend_data_q, disp_data_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    tick, frame_end, xfer;
  logic [NUM_DIGITS-1:0]   lz_v;
  logic                    lz_run;
  logic [3:0]              nib;

  function automatic logic [6:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: dec7 = 7'b1000000;
      4'h1: dec7 = 7'b1111001;
      4'h2: dec7 = 7'b0100100;
      4'h3: dec7 = 7'b0110000;
      4'h4: dec7 = 7'b0011001;
      4'h5: dec7 = 7'b0010010;
      4'h6: dec7 = 7'b0000010;
      4'h7: dec7 = 7'b1111000;
      4'h8: dec7 = 7'b0000000;
      4'h9: dec7 = 7'b0010000;
      4'hA: dec7 = 7'b0001000;
      4'hB: dec7 = 7'b0000011;
      4'hC: dec7 = 7'b1000110;
      4'hD: dec7 = 7'b0100001;
      4'hE: dec7 = 7'b0000110;
      default: dec7 = 7'b0001110;
    endcase
  endfunction

  assign tick              = (presc_q == PRE_MAX);
  assign frame_end         = tick && (idx_q == IDX_MAX);
  assign load_if.load_ready = !pending_q;
  assign xfer              = load_if.load_valid && !pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // xfer needs pending clear and apply needs it set, so the two never collide;
  // a load landing on frame_end therefore waits for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
    end else if (xfer) begin
      pending_q   <= 1'b1;
      pend_data_q <= load_if.load_data;
      pend_dp_q   <= load_if.load_dp;
    end else if (frame_end && pending_q) begin
      pending_q   <= 1'b0;
      disp_data_q <= pend_data_q;
      disp_dp_q   <= pend_dp_q;
    end
  end

  // lz_v[i] is set when nibbles i..top are all zero
  always_comb begin
    lz_v   = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run  = lz_run & (disp_data_q[4*i +: 4] == 4'h0);
      lz_v[i] = lz_run;
    end
  end

  assign nib = disp_data_q[4*idx_q +: 4];

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7f;
    dp_d  = 1'b1;
    if (presc_q != '0) begin
      an_d  = ~(AN_ONE << idx_q);
      seg_d = (blank_lz_i && (idx_q != '0) && lz_v[idx_q]) ? 7'h7f : dec7(nib);
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= 7'h7f;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;
endmodule
